// File: rtl/iram_fetch_sched_pkg.sv
// rtl/iram_fetch_sched_pkg.sv - shared types and constants for the IRAM fetch scheduler
package iram_fetch_sched_pkg;

  localparam int NUM_CORES = 4;
  localparam int PC_W      = 6;
  localparam int INS_W     = 21;
  localparam int OPC_W     = 5;
  localparam int DEPTH     = 52;

  localparam logic [OPC_W-1:0] END_OPC  = 5'b00010;
  localparam logic [PC_W-1:0]  PC_LIMIT = PC_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_end(input logic [INS_W-1:0] ins);
    return ins[INS_W-1 -: OPC_W] == END_OPC;
  endfunction

endpackage

// File: rtl/iram_fetch_sched_if.sv
// rtl/iram_fetch_sched_if.sv - per-core fetch request / response bundle
interface iram_fetch_sched_if;
  import iram_fetch_sched_pkg::*;

  logic [NUM_CORES-1:0] req;
  logic [PC_W-1:0]      PC0, PC1, PC2, PC3;
  logic [INS_W-1:0]     INS_0, INS_1, INS_2, INS_3;
  logic [NUM_CORES-1:0] ins_valid;
  logic [NUM_CORES-1:0] err;
  logic [NUM_CORES-1:0] done;

  modport master (
    output req, PC0, PC1, PC2, PC3,
    input  INS_0, INS_1, INS_2, INS_3, ins_valid, err, done
  );

  modport slave (
    input  req, PC0, PC1, PC2, PC3,
    output INS_0, INS_1, INS_2, INS_3, ins_valid, err, done
  );

endinterface

// File: rtl/iram_fetch_sched_rr_arbiter4.sv
// rtl/iram_fetch_sched_rr_arbiter4.sv - combinational 4-way round-robin arbiter
module rr_arbiter4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  logic [1:0] idx;

  // First eligible requester at or above the pointer, wrapping mod 4.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iram_fetch_sched.sv
// rtl/iram_fetch_sched.sv - round-robin sharing of one IRAM read port among four cores
module iram_fetch_sched
  import iram_fetch_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  iram_fetch_sched_if.slave    core,
  output logic [PC_W-1:0]      iram_pc,
  input  logic [INS_W-1:0]     iram_ins,
  output logic                 busy,
  output logic                 all_done
);

  state_t               state_q, state_d;
  logic [1:0]           ptr_q;
  logic [NUM_CORES-1:0] pending_q;
  logic [NUM_CORES-1:0] done_q;
  logic [NUM_CORES-1:0] err_q;
  logic [INS_W-1:0]     ins_q [NUM_CORES];

  logic                 run;
  logic                 start_go;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] gnt;
  logic [1:0]           gnt_idx;
  logic                 gnt_valid;
  logic [PC_W-1:0]      pc_sel;
  logic                 oor;

  assign run      = (state_q == ST_RUN);
  assign start_go = start && !run;
  assign eligible = run ? (core.req & ~done_q & ~pending_q) : '0;

  rr_arbiter4 u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    pc_sel = core.PC0;
    case (gnt_idx)
      2'd0:    pc_sel = core.PC0;
      2'd1:    pc_sel = core.PC1;
      2'd2:    pc_sel = core.PC2;
      default: pc_sel = core.PC3;
    endcase
  end

  assign iram_pc = gnt_valid ? pc_sel : '0;
  assign oor     = (pc_sel >= PC_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (done_q == 4'b1111) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // The pending mask doubles as the ins_valid pulse: both mark last cycle's grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      pending_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
      for (int k = 0; k < NUM_CORES; k++) ins_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= '0;
      if (start_go) begin
        ptr_q  <= '0;
        done_q <= '0;
        err_q  <= '0;
      end else if (gnt_valid) begin
        ptr_q     <= gnt_idx + 2'd1;
        pending_q <= gnt;
        if (oor) begin
          ins_q[gnt_idx]  <= '0;
          err_q[gnt_idx]  <= 1'b1;
          done_q[gnt_idx] <= 1'b1;
        end else begin
          ins_q[gnt_idx] <= iram_ins;
          if (is_end(iram_ins)) done_q[gnt_idx] <= 1'b1;
        end
      end
    end
  end

  assign core.INS_0     = ins_q[0];
  assign core.INS_1     = ins_q[1];
  assign core.INS_2     = ins_q[2];
  assign core.INS_3     = ins_q[3];
  assign core.ins_valid = pending_q;
  assign core.err       = err_q;
  assign core.done      = done_q;

  assign busy     = (state_q == ST_RUN);
  assign all_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_iram_fetch_sched.sv
// tb/tb_iram_fetch_sched.sv - scoreboard bench for iram_fetch_sched
module tb_iram_fetch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  iram_pc;
  logic [20:0] iram_ins;
  logic        busy;
  logic        all_done;

  iram_fetch_sched_if fif();

  iram_fetch_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .core     (fif),
    .iram_pc  (iram_pc),
    .iram_ins (iram_ins),
    .busy     (busy),
    .all_done (all_done)
  );

  always #5 clk = ~clk;

  localparam logic [20:0] W_SPEC = 21'b010000100110000000000;
  localparam logic [20:0] W_END  = 21'b000100000000000000000;

  logic [20:0] iram_mem [64];
  assign iram_ins = iram_mem[iram_pc];

  typedef struct {
    logic [1:0]  core;
    logic [20:0] ins;
    logic        d;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req_v);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [20:0] w, input logic d, input logic e);
    exp_t x;
    x.core = c; x.ins = w; x.d = d; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] ins_of(input logic [1:0] c);
    case (c)
      2'd0:    return fif.INS_0;
      2'd1:    return fif.INS_1;
      2'd2:    return fif.INS_2;
      default: return fif.INS_3;
    endcase
  endfunction

  // Monitor: every ins_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (fif.ins_valid != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got ins_valid=%b expected none", fif.ins_valid);
      end else begin
        exp_t x;
        logic [3:0] oh;
        x  = exp_q.pop_front();
        oh = 4'b0001 << x.core;
        if (fif.ins_valid !== oh || ins_of(x.core) !== x.ins ||
            fif.done[x.core] !== x.d || fif.err[x.core] !== x.e) begin
          errors++;
          $display("FAIL response_core%0d: got valid=%b ins=%h done=%b err=%b expected valid=%b ins=%h done=%b err=%b",
                   x.core, fif.ins_valid, ins_of(x.core), fif.done[x.core], fif.err[x.core],
                   oh, x.ins, x.d, x.e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) iram_mem[i] = 21'h1ABCD;
    iram_mem[0]  = 21'h0ABCD;
    iram_mem[1]  = 21'h15555;
    iram_mem[2]  = 21'h0F0F0;
    iram_mem[3]  = W_SPEC;
    iram_mem[51] = W_END;

    rst = 1'b1; start = 1'b0;
    fif.req = 4'b0000;
    fif.PC0 = 6'd0; fif.PC1 = 6'd0; fif.PC2 = 6'd0; fif.PC3 = 6'd0;
    tick(); tick();

    // Reset state
    chk("rst_iram_pc", 32'(iram_pc), 32'd0);
    chk("rst_ins_valid", 32'(fif.ins_valid), 32'd0);
    chk("rst_err_done", 32'({fif.err, fif.done}), 32'd0);
    chk("rst_busy_all_done", 32'({busy, all_done}), 32'd0);
    chk("rst_ins_or", 32'(fif.INS_0 | fif.INS_1 | fif.INS_2 | fif.INS_3), 32'd0);

    // Requests ignored in IDLE
    rst = 1'b0;
    fif.req = 4'b1111;
    fif.PC0 = 6'd0; fif.PC1 = 6'd1; fif.PC2 = 6'd2; fif.PC3 = 6'd3;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_no_grant", 32'({fif.ins_valid, iram_pc}), 32'd0);
      tick();
    end
    fif.req = 4'b0000;

    // Single core
    start = 1'b1; fif.req = 4'b0001; fif.PC0 = 6'd3;
    tick();
    start = 1'b0;
    #1;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_c1_pc", 32'(iram_pc), 32'd3);
    push(2'd0, W_SPEC, 1'b0, 1'b0);
    tick();
    chk("single_c2_pc", 32'(iram_pc), 32'd0);
    tick();
    chk("single_c3_pc", 32'(iram_pc), 32'd3);
    push(2'd0, W_SPEC, 1'b0, 1'b0);
    tick();
    fif.req = 4'b0000;

    // Full contention from a fresh start (pointer 0)
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b1; fif.req = 4'b1111;
    fif.PC0 = 6'd0; fif.PC1 = 6'd1; fif.PC2 = 6'd2; fif.PC3 = 6'd3;
    tick();
    start = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant_pc", 32'(iram_pc), 32'(i % 4));
      push(2'(i % 4), iram_mem[i % 4], 1'b0, 1'b0);
      tick();
    end
    fif.req = 4'b0000;

    // END termination on core 2
    fif.req = 4'b0100; fif.PC2 = 6'd51;
    #1;
    chk("end_grant_pc", 32'(iram_pc), 32'd51);
    push(2'd2, W_END, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("end_no_regrant", 32'(iram_pc), 32'd0);
      tick();
    end
    fif.req = 4'b0000;

    // Out-of-range PC on core 1
    fif.req = 4'b0010; fif.PC1 = 6'd60;
    #1;
    chk("oor_grant_pc", 32'(iram_pc), 32'd60);
    push(2'd1, 21'd0, 1'b1, 1'b1);
    tick();
    fif.req = 4'b0000;
    #1;
    chk("oor_err_done", 32'({fif.err, fif.done}), 32'({4'b0010, 4'b0110}));

    // Terminate cores 3 and 0; pointer is at 2 so core 3 goes first
    fif.req = 4'b1001; fif.PC0 = 6'd51; fif.PC3 = 6'd51;
    #1;
    chk("fin_c3_pc", 32'(iram_pc), 32'd51);
    push(2'd3, W_END, 1'b1, 1'b0);
    tick();
    chk("fin_c0_pc", 32'(iram_pc), 32'd51);
    push(2'd0, W_END, 1'b1, 1'b0);
    tick();
    chk("fin_done_all", 32'(fif.done), 32'hF);
    chk("fin_still_run", 32'({busy, all_done}), 32'b10);
    chk("fin_no_grant", 32'(iram_pc), 32'd0);
    tick();
    chk("fin_all_done", 32'({busy, all_done}), 32'b01);
    fif.req = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("restart_state", 32'({busy, all_done}), 32'b10);
    chk("restart_flags", 32'({fif.err, fif.done}), 32'd0);

    // Reset in a grant cycle drops the fetch
    fif.req = 4'b0001; fif.PC0 = 6'd3;
    #1;
    chk("midrst_grant_pc", 32'(iram_pc), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; fif.req = 4'b0000;
    #1;
    chk("midrst_no_valid", 32'(fif.ins_valid), 32'd0);
    chk("midrst_idle", 32'({busy, all_done}), 32'b00);
    chk("midrst_ins0", 32'(fif.INS_0), 32'd0);
    tick(); tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
